receptor_serial: RTL and testbench
==================================

RECEPTOR_SERIAL -- requirements
Module: receptor_serial

Interface
REQ-001 The block SHALL have parameter CICLOS_POR_BIT, default 4, giving the clk cycles per serial bit; legal values are 2 to 255.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-004 Port rx SHALL be: input, 1 bit, asynchronous serial line, idle high, LSB first.
REQ-005 Port d SHALL be: output, 8 bits, last correctly received word; it feeds the downstream registrador data input.
REQ-006 Port en SHALL be: output, 1 bit, one-cycle load strobe for the downstream registrador.
REQ-007 Port ocupado SHALL be: output, 1 bit, high while a frame is in progress.
REQ-008 Port erro SHALL be: output, 1 bit, high when the last frame ended in a framing or parity error.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rxs.
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARIDADE and STOP, held in a 3-bit state register.
REQ-011 IDLE SHALL move to START only on a 1->0 transition of rxs; a line held low SHALL NOT retrigger a frame.
REQ-012 START SHALL wait CICLOS_POR_BIT/2 cycles (integer division) and then sample rxs: 0 -> DATA; 1 -> IDLE (false start), with no en and erro unchanged.
REQ-013 DATA SHALL sample rxs every CICLOS_POR_BIT cycles, shifting each sample into bit 7 of an internal shift register, so the first bit received ends up in bit 0.
REQ-014 DATA SHALL use a 3-bit bit counter and, after the 8th sample, move to PARIDADE if PARIDADE_EN is defined, otherwise to STOP.
REQ-015 STOP SHALL sample rxs CICLOS_POR_BIT cycles after the previous sample.
REQ-016 If the stop sample is 1 and there is no parity error, the block SHALL, on the next rising edge, load d from the shift register, assert en for exactly one cycle, clear erro and return to IDLE.
REQ-017 If the stop sample is 0, or a parity error occurred, the block SHALL set erro, keep en at 0, leave d unchanged and return to IDLE.
REQ-018 d SHALL change only on the edge that asserts en, and SHALL be stable for the whole en-high cycle, so a falling-edge capture downstream sees settled data.
REQ-019 ocupado SHALL be 0 in IDLE and 1 in every other state.
REQ-020 erro SHALL hold its value until the next completed frame or reset; a false start SHALL NOT change it.
REQ-021 The baud counter SHALL be 8 bits wide, restart at 0 on every state entry and never wrap within a state.
REQ-022 A start edge in the same cycle that en is asserted SHALL be accepted, so back-to-back frames lose no data.

Reset
REQ-023 While rst=1 the block SHALL asynchronously force: state=IDLE, d=8'h00, en=0, ocupado=0, erro=0, counters=0, shift register=0, and both synchronizer flops=1.
REQ-024 A reset mid-frame SHALL abort the frame with no en pulse; after reset release, the next 1->0 rxs edge SHALL start a clean frame.

Configuration
REQ-025 When macro PARIDADE_EN is defined, the frame SHALL be start, 8 data bits, one even-parity bit (sampled in PARIDADE after CICLOS_POR_BIT cycles), then stop; a mismatch SHALL set erro and suppress en even if the stop bit is valid.
REQ-026 When PARIDADE_EN is undefined, the PARIDADE state and the parity logic SHALL NOT be generated, and the frame SHALL be start, 8 data bits, stop.

Verification
REQ-027 With CICLOS_POR_BIT=4, sending 0xA5 with a valid stop bit -> exactly one en pulse, d=0xA5 during it, erro=0, ocupado returns to 0.
REQ-028 A rx low glitch of 1 cycle while idle -> no en, d unchanged, ocupado high then back to 0 within 4 cycles.
REQ-029 After 0xA5, sending 0x3C with stop bit 0 -> erro=1, no en, d stays 0xA5.
REQ-030 Asserting rst during data bit 4 of 0x3C -> all outputs 0 immediately; a following 0x0F frame -> en pulse with d=0x0F.
REQ-031 Sending 0x00 then 0xFF back-to-back with a single stop bit -> two en pulses with d=0x00 then d=0xFF, no erro.
REQ-032 With PARIDADE_EN defined, 0x07 with parity bit 0 -> erro=1, no en; 0x07 with parity bit 1 -> en, d=0x07, erro=0.

Source files
------------

// File: rtl/receptor_serial.sv
// receptor_serial: UART-style serial receiver that feeds a downstream registrador.
// Frame: start, 8 data bits LSB first, optional even parity (PARIDADE_EN), stop.
module receptor_serial #(
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] d,
  output logic       en,
  output logic       ocupado,
  output logic       erro
);

  // Compare points for the 8-bit baud counter.
  localparam logic [7:0] FULL = 8'(CICLOS_POR_BIT - 1);
  localparam logic [7:0] HALF = 8'((CICLOS_POR_BIT / 2) - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
`ifdef PARIDADE_EN
    PARIDADE = 3'd3,
`endif
    STOP     = 3'd4
  } state_t;

  state_t     state;
  logic       s1;
  logic       rxs;
  logic       rxs_d;
  logic [7:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic       frame_ok;

`ifdef PARIDADE_EN
  logic       par_err;

  // Stop bit valid and parity matched.
  assign frame_ok = rxs & ~par_err;
`else
  // Stop bit valid.
  assign frame_ok = rxs;
`endif

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= rx;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  end

  // Frame FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_cnt <= 3'd0;
      sh      <= 8'h00;
      d       <= 8'h00;
      en      <= 1'b0;
      ocupado <= 1'b0;
      erro    <= 1'b0;
`ifdef PARIDADE_EN
      par_err <= 1'b0;
`endif
    end else begin
      en <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (rxs_d && !rxs) begin
            state   <= START;
            ocupado <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= 8'd0;
            if (!rxs) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              state   <= IDLE;
              ocupado <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt     <= 8'd0;
            sh      <= {rxs, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef PARIDADE_EN
              state <= PARIDADE;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`ifdef PARIDADE_EN
        PARIDADE: begin
          if (cnt == FULL) begin
            cnt     <= 8'd0;
            par_err <= rxs ^ (^sh);
            state   <= STOP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL) begin
            cnt     <= 8'd0;
            state   <= IDLE;
            ocupado <= 1'b0;
            if (frame_ok) begin
              d    <= sh;
              en   <= 1'b1;
              erro <= 1'b0;
            end else begin
              erro <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 8'd0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_serial.sv
// tb_receptor_serial: directed frames with a scoreboard of expected words.
// Build with +define+PARIDADE_EN to exercise the parity bit.
module tb_receptor_serial;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] d;
  logic       en;
  logic       ocupado;
  logic       erro;

  int checks   = 0;
  int failures = 0;
  int en_count = 0;
  logic en_prev = 1'b0;
  logic [7:0] exp_q[$];

  receptor_serial #(.CICLOS_POR_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .d(d),
    .en(en),
    .ocupado(ocupado),
    .erro(erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every en pulse pops the oldest expected word.
  always @(negedge clk) begin
    if (!rst && en) begin
      en_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_en", {24'd0, d}, 32'hFFFF_FFFF);
      end else begin
        chk("en_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
      end
      chk("en_one_cycle", {31'd0, en_prev}, 32'd0);
      chk("en_erro_clear", {31'd0, erro}, 32'd0);
    end
    en_prev = en;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop_b,
                            input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(w[i]);
`ifdef PARIDADE_EN
    drive_bit((^w) ^ par_flip);
    if (stop_b && !par_flip) exp_q.push_back(w);
`else
    if (stop_b) exp_q.push_back(w);
`endif
    drive_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    logic saw_hi;
    logic [7:0] w3c;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_d", {24'd0, d}, 32'h00);
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    rst = 1'b0;
    idle(4);

    // Good 0xA5 frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(8);
    chk("a5_en_count", en_count, 1);
    chk("a5_d", {24'd0, d}, 32'hA5);
    chk("a5_erro", {31'd0, erro}, 32'd0);
    chk("a5_ocupado", {31'd0, ocupado}, 32'd0);

    // One-cycle glitch while idle: false start.
    base = en_count;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    saw_hi = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ocupado) saw_hi = 1'b1;
    end
    chk("glitch_busy_seen", {31'd0, saw_hi}, 32'd1);
    chk("glitch_ocupado", {31'd0, ocupado}, 32'd0);
    chk("glitch_no_en", en_count, base);
    chk("glitch_d", {24'd0, d}, 32'hA5);
    chk("glitch_erro", {31'd0, erro}, 32'd0);

    // 0x3C with a bad stop bit.
    base = en_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(8);
    chk("badstop_erro", {31'd0, erro}, 32'd1);
    chk("badstop_no_en", en_count, base);
    chk("badstop_d", {24'd0, d}, 32'hA5);
    chk("badstop_ocupado", {31'd0, ocupado}, 32'd0);

    // Reset in the middle of data bit 4 of 0x3C.
    base = en_count;
    w3c = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(w3c[i]);
    rx = w3c[4];
    repeat (2) @(negedge clk);
    chk("mid_busy", {31'd0, ocupado}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_d", {24'd0, d}, 32'h00);
    chk("arst_en", {31'd0, en}, 32'd0);
    chk("arst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("arst_erro", {31'd0, erro}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(8);
    chk("after_rst_en", en_count, base + 1);
    chk("after_rst_d", {24'd0, d}, 32'h0F);

    // Back-to-back 0x00 then 0xFF, single stop bit.
    base = en_count;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(8);
    chk("b2b_en_count", en_count, base + 2);
    chk("b2b_d", {24'd0, d}, 32'hFF);
    chk("b2b_erro", {31'd0, erro}, 32'd0);

`ifdef PARIDADE_EN
    base = en_count;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    chk("par_bad_erro", {31'd0, erro}, 32'd1);
    chk("par_bad_no_en", en_count, base);
    chk("par_bad_d", {24'd0, d}, 32'hFF);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    chk("par_ok_en", en_count, base + 1);
    chk("par_ok_d", {24'd0, d}, 32'h07);
    chk("par_ok_erro", {31'd0, erro}, 32'd0);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
